// File: rtl/intr_ctrl.sv
// intr_ctrl - memory-mapped fixed-priority interrupt controller.
//
// Collects NSRC asynchronous interrupt lines, synchronises them, latches
// them into PEND according to the per-source edge/level mode, gates them
// with MASK and presents the lowest-index request to the CPU on intr.
// The CPU acknowledges with inta; the granted source ID is latched for
// the handler and further requests are held until software writes EOI.
//
// Ports:
//   clock  - system clock, all state updates on the rising edge
//   reset  - asynchronous, active-high; clears all state
//   irq    - raw interrupt lines, asynchronous to clock
//   inta   - interrupt acknowledge from the CPU
//   intr   - interrupt request to the CPU (registered)
//   we     - register write strobe
//   addr   - word index: 0 PEND (W1C), 1 MASK, 2 MODE, 3 ID / EOI
//   wdata  - write data
//   rdata  - combinational read data for addr
module intr_ctrl #(
  parameter int NSRC        = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [NSRC-1:0] irq,
  input  logic            inta,
  output logic            intr,
  input  logic            we,
  input  logic [1:0]      addr,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_SERV = 2'd2;

  // Index of the lowest set bit of v (0 when v is empty).
  function automatic logic [2:0] encode_lowest(input logic [NSRC-1:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = i[2:0];
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // Stage 0 is the first synchroniser flop; the stage after the last
  // synchroniser flop is the history bit used for rising-edge detection.
  logic [NSRC-1:0] sync_r [SYNC_STAGES+1];
  logic [NSRC-1:0] level_s;
  logic [NSRC-1:0] edge_s;

  logic [NSRC-1:0] pend_r;
  logic [NSRC-1:0] mask_r;
  logic [NSRC-1:0] mode_r;
  logic [2:0]      id_r;
  logic            in_service_r;
  logic [1:0]      state_r;
  logic            intr_r;

  logic [NSRC-1:0] req_vec_s;
  logic [2:0]      win_id_s;
  logic            grant_s;
  logic            eoi_s;
  logic [NSRC-1:0] w1c_s;
  logic [NSRC-1:0] grant_clr_s;
  logic [NSRC-1:0] pend_next_s;
  logic [1:0]      state_next_s;
  logic            wdata_unused_s;

  // Only the low NSRC data bits carry register content.
  assign wdata_unused_s = ^wdata[31:NSRC];

  assign level_s   = sync_r[SYNC_STAGES-1];
  assign edge_s    = level_s & ~sync_r[SYNC_STAGES];
  assign req_vec_s = pend_r & mask_r;
  assign win_id_s  = encode_lowest(req_vec_s);

  // A grant needs a live request at the acknowledging edge; a request
  // that vanished in REQ makes inta a no-op.
  assign grant_s = (state_r == S_REQ) && (req_vec_s != {NSRC{1'b0}}) && inta;
  assign eoi_s   = we && (addr == 2'd3) && (state_r == S_SERV);
  assign w1c_s   = (we && (addr == 2'd0)) ? wdata[NSRC-1:0] : {NSRC{1'b0}};

  // Next PEND: edge sources set-dominant over W1C/grant clears, level sources track the line.
  always_comb begin
    grant_clr_s = {NSRC{1'b0}};
    pend_next_s = {NSRC{1'b0}};
    for (int i = 0; i < NSRC; i++) begin
      grant_clr_s[i] = grant_s && (win_id_s == i[2:0]);
      if (mode_r[i]) begin
        pend_next_s[i] = edge_s[i] | (pend_r[i] & ~(w1c_s[i] | grant_clr_s[i]));
      end else begin
        pend_next_s[i] = level_s[i];
      end
    end
  end

  // Request / service state machine next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (req_vec_s != {NSRC{1'b0}}) begin
          state_next_s = S_REQ;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_REQ: begin
        if (req_vec_s == {NSRC{1'b0}}) begin
          state_next_s = S_IDLE;
        end else if (inta) begin
          state_next_s = S_SERV;
        end else begin
          state_next_s = S_REQ;
        end
      end
      S_SERV: begin
        if (eoi_s) begin
          state_next_s = S_IDLE;
        end else begin
          state_next_s = S_SERV;
        end
      end
      default: state_next_s = S_IDLE;
    endcase
  end

  // Synchroniser chain for the raw irq lines.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i <= SYNC_STAGES; i++) begin
        sync_r[i] <= {NSRC{1'b0}};
      end
    end else begin
      sync_r[0] <= irq;
      for (int i = 1; i <= SYNC_STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
    end
  end

  // Software-visible configuration and pending registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pend_r <= {NSRC{1'b0}};
      mask_r <= {NSRC{1'b0}};
      mode_r <= {NSRC{1'b0}};
    end else begin
      pend_r <= pend_next_s;
      mask_r <= (we && (addr == 2'd1)) ? wdata[NSRC-1:0] : mask_r;
      mode_r <= (we && (addr == 2'd2)) ? wdata[NSRC-1:0] : mode_r;
    end
  end

  // FSM state, granted ID, in-service flag and the registered intr line.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r      <= S_IDLE;
      id_r         <= 3'd0;
      in_service_r <= 1'b0;
      intr_r       <= 1'b0;
    end else begin
      state_r <= state_next_s;
      intr_r  <= (state_next_s == S_REQ);
      // id survives EOI so the handler can still read it afterwards.
      id_r    <= grant_s ? win_id_s : id_r;
      if (grant_s) begin
        in_service_r <= 1'b1;
      end else if (eoi_s) begin
        in_service_r <= 1'b0;
      end else begin
        in_service_r <= in_service_r;
      end
    end
  end

  assign intr = intr_r;

  // Combinational register read mux; unused upper bits read as zero.
  always_comb begin
    rdata = 32'd0;
    case (addr)
      2'd0:    rdata[NSRC-1:0] = pend_r;
      2'd1:    rdata[NSRC-1:0] = mask_r;
      2'd2:    rdata[NSRC-1:0] = mode_r;
      2'd3:    rdata = {in_service_r, 28'd0, id_r};
      default: rdata = 32'd0;
    endcase
  end

endmodule
